// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit.
// Issues one memory request at a time from pc, holds the returned instruction
// for decode (with a precomputed opcode/funct pattern) and handles redirects,
// which always win over every other event.
// Optional build macro: IFU_ALIGN_CHECK_EN -- a misaligned redirect target
// traps into ERR (misalign=1) instead of being silently word-aligned.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [14:0] id_pattern,
    output logic        misalign
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;

`ifdef IFU_ALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are dropped, so a redirect can never be misaligned.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
    assign redirect_bad    = 1'b0;
`endif

    // Request is a pure function of state; held low while reset is asserted.
    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_addr      = pc;

    // Fetch FSM with registered decode-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            id_valid   <= 1'b0;
            id_inst    <= '0;
            id_pc      <= '0;
            id_pattern <= '0;
            misalign   <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        if (redirect_bad) begin
                            misalign <= 1'b1;
                            state    <= ERR;
                        end else begin
                            pc <= redirect_tgt;
                            // A request already accepted for the old pc must be flushed.
                            if (imem_req_ready) begin
                                state   <= WAIT;
                                discard <= 1'b1;
                            end
                        end
                    end else if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (redirect_bad) begin
                            misalign <= 1'b1;
                            state    <= ERR;
                        end else begin
                            pc <= redirect_tgt;
                            if (imem_resp_valid) begin
                                discard <= 1'b0;
                                state   <= REQ;
                            end else begin
                                discard <= 1'b1;
                            end
                        end
                    end else if (imem_resp_valid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            id_inst    <= imem_resp_data;
                            id_pc      <= pc;
                            id_pattern <= {imem_resp_data[31:25], imem_resp_data[14:12],
                                           imem_resp_data[6:2]};
                            id_valid   <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        id_valid <= 1'b0;
                        if (redirect_bad) begin
                            misalign <= 1'b1;
                            state    <= ERR;
                        end else begin
                            pc    <= redirect_tgt;
                            state <= REQ;
                        end
                    end else if (id_ready) begin
                        pc       <= pc + 32'd4;
                        id_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                default: begin
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a table of per-cycle vectors followed by
// hand-written sequences for reset-in-WAIT, pc wraparound and misaligned redirect.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [14:0] id_pattern;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .id_pattern(id_pattern),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        rdr;
        logic [31:0] rpc;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [14:0] e_pat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rsp,
                                input logic [31:0] data, input logic rdr,
                                input logic [31:0] rpc, input logic idr,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_idv, input logic [31:0] e_inst,
                                input logic [31:0] e_pc, input logic [14:0] e_pat);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rsp = rsp; v.data = data; v.rdr = rdr; v.rpc = rpc;
        v.idr = idr; v.e_req = e_req; v.e_addr = e_addr; v.e_idv = e_idv;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_pat = e_pat;
        return v;
    endfunction

    initial begin
        // rst rdy rsp data rdr rpc idr | req addr idv inst pc pat
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h8000_0000,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0000,0,0,0,0));
        vecs.push_back(mk(0,0,1,32'h0000_0093,0,0,0, 0,32'h8000_0000,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h8000_0000,1,32'h93,32'h8000_0000,15'h0004));
        for (int unsigned i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,1,32'hDEAD_BEEF,0,0,0,
                              0,32'h8000_0000,1,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0000,1,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,32'h8000_0004,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0004,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0100,0,
                          0,32'h8000_0004,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,1,32'h0010_0073,0,0,0,
                          0,32'h8000_0100,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0100,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,1,32'h40B5_0533,0,0,0,
                          0,32'h8000_0100,0,32'h93,32'h8000_0000,15'h0004));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0200,1,
                          0,32'h8000_0100,1,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,1,0,0,0,0,0,
                          1,32'h8000_0200,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,0,0,0,0,0,0,
                          0,32'h8000_0200,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,0,1,32'h1111_1111,1,32'h8000_0300,0,
                          0,32'h8000_0200,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0400,0,
                          1,32'h8000_0300,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,1,0,0,1,32'h8000_0500,0,
                          1,32'h8000_0400,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,0,1,32'h2222_2222,0,0,0,
                          0,32'h8000_0500,0,32'h40B5_0533,32'h8000_0100,15'h200C));
        vecs.push_back(mk(0,0,0,0,0,0,0,
                          1,32'h8000_0500,0,32'h40B5_0533,32'h8000_0100,15'h200C));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rsp;
            imem_resp_data = vecs[i].data; redirect_valid = vecs[i].rdr;
            redirect_pc = vecs[i].rpc; id_ready = vecs[i].idr;
            #1;
            check("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_req));
            check("addr", i, imem_addr, vecs[i].e_addr);
            check("id_valid", i, 32'(id_valid), 32'(vecs[i].e_idv));
            check("id_inst", i, id_inst, vecs[i].e_inst);
            check("id_pc", i, id_pc, vecs[i].e_pc);
            check("id_pattern", i, 32'(id_pattern), 32'(vecs[i].e_pat));
            check("misalign", i, 32'(misalign), 32'd0);
        end

        // Reset asserted while a request is outstanding.
        @(negedge clk);
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1;
        check("rstwait_pre_req", 0, 32'(imem_req_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rstwait_req", 0, 32'(imem_req_valid), 32'd0);
        check("rstwait_addr", 0, imem_addr, 32'h8000_0000);
        check("rstwait_idv", 0, 32'(id_valid), 32'd0);
        check("rstwait_inst", 0, id_inst, 32'd0);
        check("rstwait_pc", 0, id_pc, 32'd0);
        check("rstwait_pat", 0, 32'(id_pattern), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstrel_req", 0, 32'(imem_req_valid), 32'd1);
        check("rstrel_addr", 0, imem_addr, 32'h8000_0000);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        check("stray_resp_req", 0, 32'(imem_req_valid), 32'd1);
        check("stray_resp_idv", 0, 32'(id_valid), 32'd0);

        // pc wraps from 0xFFFF_FFFC to 0 after consumption.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        check("wrap_addr", 0, imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        @(negedge clk);
        imem_resp_valid = 1'b0; id_ready = 1'b1;
        #1;
        check("wrap_idv", 0, 32'(id_valid), 32'd1);
        check("wrap_idpc", 0, id_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        id_ready = 1'b0;
        #1;
        check("wrap_next_addr", 0, imem_addr, 32'h0000_0000);
        check("wrap_next_req", 0, 32'(imem_req_valid), 32'd1);

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            check("err_misalign", i, 32'(misalign), 32'd1);
            check("err_req", i, 32'(imem_req_valid), 32'd0);
            check("err_idv", i, 32'(id_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("err_rst_misalign", 0, 32'(misalign), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("err_rst_req", 0, 32'(imem_req_valid), 32'd1);
        check("err_rst_addr", 0, imem_addr, 32'h8000_0000);
`else
        check("align_addr", 0, imem_addr, 32'h8000_0000);
        check("align_req", 0, 32'(imem_req_valid), 32'd1);
        check("align_misalign", 0, 32'(misalign), 32'd0);
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request.
REQ-005 imem_req_ready  input  1  SHALL flag that memory accepts the request.
REQ-006 imem_addr  output  32  SHALL carry the fetch address (current pc).
REQ-007 imem_resp_valid  input  1  SHALL flag returned instruction data.
REQ-008 imem_resp_data  input  32  SHALL carry the returned instruction.
REQ-009 redirect_valid  input  1  SHALL flag a jump/branch redirect.
REQ-010 redirect_pc  input  32  SHALL carry the redirect target.
REQ-011 id_valid  output  1  SHALL flag a held instruction for the decode lookup stage.
REQ-012 id_ready  input  1  SHALL flag that decode consumes the instruction.
REQ-013 id_inst  output  32  SHALL carry the held instruction.
REQ-014 id_pc  output  32  SHALL carry the address of id_inst.
REQ-015 id_pattern  output  15  SHALL carry {inst[31:25], inst[14:12], inst[6:2]} of id_inst.
REQ-016 misalign  output  1  SHALL flag a misaligned redirect (see Configuration).

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, ERR.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready go to WAIT next cycle; otherwise stay in REQ.
REQ-019 imem_req_valid SHALL be 0 in WAIT, HOLD, ERR.
REQ-020 WAIT: on imem_resp_valid with discard=0, register id_inst, id_pc=pc, id_pattern, set id_valid=1, go to HOLD.
REQ-021 WAIT: on imem_resp_valid with discard=1, clear discard, drop data, go to REQ.
REQ-022 HOLD: id_inst/id_pc/id_pattern SHALL stay stable while id_valid=1 and id_ready=0.
REQ-023 HOLD: on id_valid&&id_ready, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), id_valid<=0, go to REQ.
REQ-024 Best-case latency: REQ handshake in cycle N, response in cycle N+1 -> id_valid=1 in cycle N+2.
REQ-025 Redirect SHALL take priority over every other event in REQ, WAIT, HOLD: pc<=redirect_pc.
REQ-026 Redirect in REQ without req handshake: stay REQ; next request uses redirect_pc.
REQ-027 Redirect in REQ with simultaneous req handshake: go WAIT with discard=1.
REQ-028 Redirect in WAIT: discard<=1 unless imem_resp_valid is high that cycle; if it is high, drop the response and go to REQ.
REQ-029 Redirect in HOLD: id_valid<=0, go to REQ, no pc+4, regardless of id_ready.
REQ-030 At most one outstanding memory request SHALL exist.

Reset
REQ-031 rst SHALL asynchronously force state=REQ, pc=RESET_PC, discard=0, id_valid=0, id_inst=0, id_pc=0, id_pattern=0, misalign=0.
REQ-032 imem_req_valid SHALL assert in the first cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-033 Reset mid-transaction SHALL abandon any outstanding request; a response arriving after reset with no request issued SHALL be ignored.

Configuration
REQ-034 With IFU_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set misalign=1 and enter ERR; ERR issues no requests, keeps id_valid=0, and exits only on rst.
REQ-035 Without IFU_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 2'b00, misalign tied to 0, and ERR unreachable.

Verification
REQ-036 Scenario: reset release, memory ready immediately, response 32'h0000_0093 next cycle -> id_valid in cycle 2, id_pc=32'h8000_0000, id_pattern=15'b0000000_000_00100.
REQ-037 Scenario: id_ready held 0 for 5 cycles -> id_* stable and no new request; then id_ready=1 -> next imem_addr=32'h8000_0004.
REQ-038 Scenario: redirect to 32'h8000_0100 in WAIT, response 32'h0010_0073 one cycle later -> response dropped, next imem_addr=32'h8000_0100.
REQ-039 Scenario: redirect to 32'h8000_0200 in HOLD with id_ready=1 -> id_valid drops, next imem_addr=32'h8000_0200, not +4.
REQ-040 Scenario: with IFU_ALIGN_CHECK_EN, redirect_pc=32'h8000_0002 -> misalign=1, imem_req_valid stays 0 until rst; without it -> imem_addr=32'h8000_0000.
REQ-041 Scenario: rst asserted in WAIT -> outputs zero immediately, and after release imem_addr=RESET_PC.
